if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter ADDR_W, default 32, PC width in bits.
REQ-002 Parameter INST_W, default 32, instruction width in bits.
REQ-003 Parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-004 Parameter NOP_INST, default 32'h00000013, instruction presented when the queue is empty.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 flush  input  1  jump/redirect from decode; discards all queued entries.
REQ-008 if_valid  input  1  fetch offers an entry this cycle.
REQ-009 if_pc  input  ADDR_W  PC of the offered entry.
REQ-010 if_inst  input  INST_W  instruction of the offered entry.
REQ-011 if_ready  output  1  queue accepts an entry this cycle.
REQ-012 id_ready  input  1  decode consumes the head this cycle (deasserted = stall).
REQ-013 id_valid  output  1  head entry is valid.
REQ-014 id_pc  output  ADDR_W  PC of the head entry.
REQ-015 id_inst  output  INST_W  instruction of the head entry.
REQ-016 count  output  clog2(DEPTH+1)  number of occupied entries.

Function
REQ-017 The queue SHALL be a circular FIFO with read and write pointers of clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-018 The block SHALL define push = if_valid & if_ready and pop = id_valid & id_ready.
REQ-019 if_ready SHALL equal (count != DEPTH), derived from registered state only, with no combinational path from id_ready or flush.
REQ-020 id_valid SHALL equal (count != 0).
REQ-021 id_pc and id_inst SHALL combinationally reflect the entry at the read pointer whenever id_valid=1.
REQ-022 When id_valid=0, id_pc SHALL be 0 and id_inst SHALL be NOP_INST.
REQ-023 Latency: an entry pushed at edge N SHALL appear at id_* after edge N, including when the queue was empty. No same-cycle bypass is allowed.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-025 Push only SHALL increment count; pop only SHALL decrement it.
REQ-026 When full, no push SHALL occur even if pop=1 in the same cycle.
REQ-027 id_ready with the queue empty SHALL have no effect.
REQ-028 flush=1 SHALL, at the next edge, set count and both pointers to 0 and discard any simultaneous push and pop.
REQ-029 flush SHALL take priority over push and pop.
REQ-030 Entries SHALL leave the queue strictly in push order, and no entry may be duplicated or dropped except by flush.
REQ-031 Storage contents SHALL NOT be observable except through REQ-021.

Reset
REQ-032 rst=1 SHALL, at the next edge, clear count and both pointers to 0. Outputs after that edge: if_ready=1, id_valid=0, id_pc=0, id_inst=NOP_INST.
REQ-033 rst SHALL take priority over flush, push and pop, including mid-operation with a full queue.
REQ-034 The storage array SHALL NOT require reset.

Structure
REQ-035 Default widths, NOP_INST and the Jump/Stop level constants SHALL come from the shared defs package; the block SHALL NOT hard-code literals for them.
REQ-036 The block SHALL be a single module with no sub-module. Storage SHALL be an internal register array.

Verification
REQ-037 Reset: hold rst 2 cycles while if_valid=1 -> count=0, id_valid=0, id_inst=32'h00000013, if_ready=1.
REQ-038 Fill: push pc 0x0,0x4,0x8,0xC with id_ready=0 -> count=4, if_ready=0; a fifth push of pc 0x10 is refused; id_pc=0x0.
REQ-039 Drain and wrap: from full, id_ready=1 while pushing 0x10, 0x14 once space opens -> outputs 0x0,0x4,0x8,0xC,0x10,0x14 in order; pointers wrap with no loss.
REQ-040 Flush: queue holds 3 entries; assert flush while if_valid=1 with pc 0x40 -> next cycle count=0, id_valid=0, and 0x40 is not stored.
REQ-041 Stall: with 2 entries, id_ready=0 for 5 cycles -> id_pc is held constant and count=2 throughout.
REQ-042 Concurrency: count=2 with simultaneous push and pop -> count stays 2; reset asserted while full -> empty state as in REQ-037.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared defaults for the fetch/decode queue: widths, depth, bubble instruction
// and the active levels of the redirect (jump) and stall (stop) controls.
package if_id_queue_pkg;

  localparam int          DEF_ADDR_W   = 32;
  localparam int          DEF_INST_W   = 32;
  localparam int          DEF_DEPTH    = 4;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

  // Level of flush that means "jump/redirect", and level of id_ready that means "stall".
  localparam logic JUMP_LVL = 1'b1;
  localparam logic STOP_LVL = 1'b0;

endpackage

// File: rtl/if_id_queue.sv
// Circular FIFO between fetch and decode. The head is presented combinationally
// from registered state; pushed entries become visible one edge later.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INST_W   = DEF_INST_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(DEF_NOP_INST)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         if_valid,
  input  logic [ADDR_W-1:0]            if_pc,
  input  logic [INST_W-1:0]            if_inst,
  output logic                         if_ready,
  input  logic                         id_ready,
  output logic                         id_valid,
  output logic [ADDR_W-1:0]            id_pc,
  output logic [INST_W-1:0]            id_inst,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_jump;
  logic w_consume;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_jump    = (flush == JUMP_LVL);
  assign w_consume = (id_ready != STOP_LVL);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);

  // if_ready depends only on r_count, so a full queue refuses even while popping.
  assign w_push = if_valid & ~w_full;
  assign w_pop  = ~w_empty & w_consume;

  assign if_ready = ~w_full;
  assign id_valid = ~w_empty;
  assign id_pc    = w_empty ? '0       : r_pc_mem[r_rd_ptr];
  assign id_inst  = w_empty ? NOP_INST : r_inst_mem[r_rd_ptr];
  assign count    = r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || w_jump) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never reset; stale slots are hidden by the empty/valid masking above.
  always_ff @(posedge clk) begin
    if (!rst && !w_jump && w_push) begin
      r_pc_mem[r_wr_ptr]   <= if_pc;
      r_inst_mem[r_wr_ptr] <= if_inst;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Randomized and directed bench for if_id_queue against a queue-based model.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, flush, if_valid, id_ready;
  logic [31:0] if_pc, if_inst;
  logic        if_ready, id_valid;
  logic [31:0] id_pc, id_inst;
  logic [2:0]  count;

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .count(count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] model_q[$];
  logic        last_push, last_pop;
  logic [31:0] last_pop_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle from posedge+1, compare outputs at negedge, step the model at the edge.
  task automatic cycle(input logic r, input logic f, input logic v, input logic rdy,
                       input logic [31:0] pc);
    logic [31:0] inst;
    int sz;
    inst     = $urandom;
    rst      = r;
    flush    = f;
    if_valid = v;
    id_ready = rdy;
    if_pc    = pc;
    if_inst  = inst;
    @(negedge clk);
    sz = model_q.size();
    check("count",    64'(count),    64'(sz));
    check("if_ready", 64'(if_ready), 64'(sz != DEPTH));
    check("id_valid", 64'(id_valid), 64'(sz != 0));
    check("id_pc",    64'(id_pc),    sz != 0 ? 64'(model_q[0][63:32]) : 64'd0);
    check("id_inst",  64'(id_inst),  sz != 0 ? 64'(model_q[0][31:0])  : 64'(NOP));
    last_push   = 1'b0;
    last_pop    = 1'b0;
    last_pop_pc = id_pc;
    if (r || f) begin
      model_q.delete();
    end else begin
      last_push = v && (sz < DEPTH);
      last_pop  = rdy && (sz > 0);
      if (last_pop)  void'(model_q.pop_front());
      if (last_push) model_q.push_back({pc, inst});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] popped[$];
    logic [31:0] nxt, held;

    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    if_pc = '0; if_inst = '0;
    @(posedge clk);
    #1;

    // Reset held 2 cycles with fetch offering
    cycle(1, 0, 1, 0, 32'h100);
    cycle(1, 0, 1, 0, 32'h104);
    check("rst_count",    64'(count),    64'd0);
    check("rst_id_valid", 64'(id_valid), 64'd0);
    check("rst_id_inst",  64'(id_inst),  64'h13);
    check("rst_if_ready", 64'(if_ready), 64'd1);

    // Fill, then a fifth push is refused
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 32'(4 * i));
    check("fill_count",    64'(count),    64'd4);
    check("fill_if_ready", 64'(if_ready), 64'd0);
    cycle(0, 0, 1, 0, 32'h10);
    check("fifth_refused", 64'(last_push), 64'd0);
    check("fill_head",     64'(id_pc),     64'd0);

    // Drain from full while pushing 0x10, 0x14 as space opens
    nxt = 32'h10;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, nxt <= 32'h14, 1, nxt);
      if (last_pop)  popped.push_back(last_pop_pc);
      if (last_push) nxt += 32'h4;
    end
    check("drain_n", 64'(popped.size()), 64'd6);
    for (int i = 0; i < popped.size() && i < 6; i++)
      check("drain_order", 64'(popped[i]), 64'(4 * i));
    check("drain_empty", 64'(count), 64'd0);

    // Flush with 3 entries while fetch offers 0x40
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 32'h20 + 32'(4 * i));
    check("pre_flush_count", 64'(count), 64'd3);
    cycle(0, 1, 1, 1, 32'h40);
    check("flush_count",    64'(count),    64'd0);
    check("flush_id_valid", 64'(id_valid), 64'd0);
    cycle(0, 0, 0, 0, 32'h0);
    check("flush_no_40", 64'(id_valid), 64'd0);

    // Stall with 2 entries
    cycle(0, 0, 1, 0, 32'h50);
    cycle(0, 0, 1, 0, 32'h54);
    held = id_pc;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 32'h0);
      check("stall_pc",    64'(id_pc), 64'(held));
      check("stall_count", 64'(count), 64'd2);
    end
    check("stall_head", 64'(held), 64'h50);

    // Simultaneous push and pop at count 2
    cycle(0, 0, 1, 1, 32'h58);
    check("pushpop_count", 64'(count), 64'd2);
    check("pushpop_head",  64'(id_pc), 64'h54);

    // Reset while full
    cycle(0, 0, 1, 0, 32'h5C);
    cycle(0, 0, 1, 0, 32'h60);
    check("full_count", 64'(count), 64'd4);
    cycle(1, 1, 1, 1, 32'h64);
    check("rstfull_count",    64'(count),    64'd0);
    check("rstfull_id_valid", 64'(id_valid), 64'd0);
    check("rstfull_id_inst",  64'(id_inst),  64'h13);
    check("rstfull_id_pc",    64'(id_pc),    64'd0);
    check("rstfull_if_ready", 64'(if_ready), 64'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 64) == 0, ($urandom % 16) == 0,
            ($urandom % 10) < 7, ($urandom % 10) < 6, $urandom);
    end
    cycle(0, 0, 0, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
